arcade_input_cond: RTL and testbench
====================================

Name: arcade_input_cond

Overview:
- Input conditioner between the raw player controls (keyboard/joystick button registers) and the arcade core's active-low input ports.
- Each bit of the raw button vector is synchronised and debounced.
- The raw coin request is converted into frame-timed coin pulses, with a lockout gap and a small pending queue, so the core's coin logic never misses or merges coins.
- Outputs are active-high; the top level inverts and masks them into in0/in1 as today.

Parameters:
NBTN, 8, number of general button/direction bits conditioned
DEB_W, 16, width of each debounce counter
DEB_CNT, 30000, cycles a synced input must differ from the stable value before it is accepted (DEB_CNT >= 1, < 2**DEB_W)
COIN_FRAMES, 4, number of vblank rising edges coin_out is held high per coin
COIN_GAP, 4, number of vblank rising edges coin_out is held low after each pulse
QMAX, 3, maximum number of pending coin requests (2-bit counter)

Ports:
CLK  in  1  system clock (clk_sys)
RESET  in  1  asynchronous reset, active-high
vblank  in  1  core vertical blank, CLK domain
btn_in  in  NBTN  raw buttons, active-high, asynchronous
coin_in  in  1  raw coin request (OR of all coin sources), active-high, asynchronous
btn_out  out  NBTN  debounced buttons, active-high
coin_out  out  1  shaped coin pulse to core, active-high
coin_busy  out  1  high while state is PULSE or GAP, or pending != 0
coin_drop  out  1  single-cycle strobe, coin request discarded (queue full)

Behaviour:
Clock and reset:
- One clock, CLK.
- RESET is asynchronous and active-high, and clears every flop, including synchronisers.

Reset values:
- btn_out=0, coin_out=0, coin_busy=0, coin_drop=0.
- Debounce counters=0, stable values=0, pending=0, frame counter=0, state=IDLE.

Synchronisation:
- btn_in and coin_in each pass through 2-flop synchronisers.
- vblank is not synchronised.

Debounce (per bit, NBTN+1 instances; coin is bit NBTN internally):
- If synced == stable: counter <= 0.
- Otherwise counter increments each cycle; on the cycle counter == DEB_CNT-1, stable <= synced and counter <= 0.
- A glitch shorter than DEB_CNT cycles never changes stable.
- Latency from a clean edge on input to btn_out change is 2 + DEB_CNT cycles.
- btn_out = stable[NBTN-1:0].

Coin event and frame tick:
- Coin event = rising edge of debounced coin: stable_coin & ~stable_coin_d, one cycle.
- Frame tick = vblank & ~vblank_d.

Coin FSM (states IDLE, PULSE, GAP), frame counter fcnt of 3+ bits:
- IDLE:
  - If event or pending != 0: go to PULSE, fcnt <= 0, coin_out <= 1 (registered, high the cycle after the decision).
  - If pending != 0 and no event: pending decrements.
  - If pending != 0 and event: pending is unchanged.
- PULSE:
  - On each tick, fcnt++.
  - When a tick makes fcnt reach COIN_FRAMES: go to GAP, fcnt <= 0, coin_out <= 0.
- GAP:
  - On each tick, fcnt++.
  - When fcnt reaches COIN_GAP: go to IDLE.
- Events in PULSE or GAP: pending++ if pending < QMAX.
- Queue full: if pending == QMAX, the event is dropped and coin_drop=1 for exactly that cycle.
- A tick on the same cycle as the PULSE entry decision is ignored; counting starts the following cycle.
- Pulse width is exactly COIN_FRAMES ticks, and the gap is exactly COIN_GAP ticks.

coin_busy:
- Combinational: (state != IDLE) | (pending != 0).

Boundaries:
- vblank held constantly high: no ticks, so coin_out stays high indefinitely. This is acceptable, because the core always toggles vblank.
- RESET mid-pulse: coin_out drops immediately (async) and pending is lost.
- A held coin button produces one event only.

Test Plan:
All scenarios use DEB_CNT=4, COIN_FRAMES=2, COIN_GAP=2, with vblank rising every 20 cycles.
1. btn_in[0] pulse 3 cycles -> btn_out stays 0. btn_in[0] held 10 cycles -> btn_out[0] rises exactly 6 cycles after the input edge and falls 6 cycles after release.
2. Single debounced coin press in IDLE -> coin_out high the next cycle, low after the 2nd vblank tick, coin_busy low after 2 further ticks, coin_drop never asserted.
3. Three coin presses during one PULSE -> pending=3, and coin_out produces 4 separate pulses, each 2 ticks wide with 2-tick gaps. A 5th press while pending=3 -> coin_drop=1 for one cycle and no extra pulse.
4. Coin event coincident with a vblank tick in IDLE -> pulse still lasts exactly 2 subsequent ticks.
5. RESET asserted for 1 cycle mid-PULSE with pending=2 -> coin_out, coin_busy and btn_out go 0 asynchronously, and no pulses follow after release.
6. Coin held continuously for 200 cycles -> exactly one pulse, pending stays 0.

Source files
------------

// File: rtl/arcade_input_cond.sv
`timescale 1ns/1ps
// arcade_input_cond
// Conditions raw player controls before they reach the arcade core.
// Every button bit and the coin request are synchronised and debounced;
// the debounced coin is turned into frame-timed pulses with a lockout gap
// and a small pending queue, so the core never misses or merges coins.
//
// Ports:
//   CLK        system clock
//   RESET      asynchronous reset, active-high, clears every flop
//   vblank     core vertical blank (already in CLK domain)
//   btn_in     raw buttons, active-high, asynchronous
//   coin_in    raw coin request, active-high, asynchronous
//   btn_out    debounced buttons, active-high
//   coin_out   shaped coin pulse, COIN_FRAMES vblank ticks wide
//   coin_busy  coin shaper active or coins pending
//   coin_drop  one-cycle strobe when a coin is discarded (queue full)
module arcade_input_cond #(
    parameter int unsigned NBTN        = 8,
    parameter int unsigned DEB_W       = 16,
    parameter int unsigned DEB_CNT     = 30000,
    parameter int unsigned COIN_FRAMES = 4,
    parameter int unsigned COIN_GAP    = 4,
    parameter int unsigned QMAX        = 3
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            vblank,
    input  logic [NBTN-1:0] btn_in,
    input  logic            coin_in,
    output logic [NBTN-1:0] btn_out,
    output logic            coin_out,
    output logic            coin_busy,
    output logic            coin_drop
);
    // Coin is conditioned as bit NBTN alongside the buttons.
    localparam int unsigned NB = NBTN + 1;
    localparam int unsigned FW = 4;

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CNT - 1);
    localparam logic [FW-1:0]    FRAMES_END = FW'(COIN_FRAMES);
    localparam logic [FW-1:0]    GAP_END    = FW'(COIN_GAP);
    localparam logic [1:0]       QFULL      = 2'(QMAX);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } coin_state_t;

    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    stable;
    logic [DEB_W-1:0] deb_cnt [NB];

    logic stable_coin_d;
    logic vblank_d;
    logic coin_evt;
    logic tick;

    coin_state_t state;
    coin_state_t state_nx;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_nx;
    logic [1:0]    pending;
    logic [1:0]    pending_nx;
    logic          coin_out_nx;

    assign raw = {coin_in, btn_in};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A synced value must differ from the stable value for DEB_CNT
    // consecutive cycles before it is accepted; any agreement restarts.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stable <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_out = stable[NBTN-1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stable_coin_d <= 1'b0;
            vblank_d      <= 1'b0;
        end else begin
            stable_coin_d <= stable[NBTN];
            vblank_d      <= vblank;
        end
    end

    assign coin_evt = stable[NBTN] & ~stable_coin_d;
    assign tick     = vblank & ~vblank_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            fcnt     <= '0;
            pending  <= '0;
            coin_out <= 1'b0;
        end else begin
            state    <= state_nx;
            fcnt     <= fcnt_nx;
            pending  <= pending_nx;
            coin_out <= coin_out_nx;
        end
    end

    // Ticks are only counted while already in PULSE/GAP, so a tick that
    // coincides with the IDLE->PULSE decision does not shorten the pulse.
    always_comb begin
        state_nx   = state;
        fcnt_nx    = fcnt;
        pending_nx = pending;
        coin_drop  = 1'b0;
        case (state)
            IDLE: begin
                if (coin_evt || (pending != '0)) begin
                    state_nx = PULSE;
                    fcnt_nx  = '0;
                    // A fresh event takes the slot of the queued coin.
                    if (!coin_evt) begin
                        pending_nx = pending - 1'b1;
                    end
                end
            end
            PULSE: begin
                if (tick) begin
                    if (fcnt + 1'b1 == FRAMES_END) begin
                        state_nx = GAP;
                        fcnt_nx  = '0;
                    end else begin
                        fcnt_nx = fcnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (fcnt + 1'b1 == GAP_END) begin
                        state_nx = IDLE;
                        fcnt_nx  = '0;
                    end else begin
                        fcnt_nx = fcnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                fcnt_nx  = '0;
            end
        endcase
        if ((state != IDLE) && coin_evt) begin
            if (pending < QFULL) begin
                pending_nx = pending + 1'b1;
            end else begin
                coin_drop = 1'b1;
            end
        end
        coin_out_nx = (state_nx == PULSE);
    end

    assign coin_busy = (state != IDLE) | (pending != '0);

endmodule

// File: tb/tb_arcade_input_cond.sv
`timescale 1ns/1ps
// Bench for arcade_input_cond with DEB_CNT=4, COIN_FRAMES=2, COIN_GAP=2
// and vblank rising every 20 cycles. Debounce behaviour is driven from a
// vector table; coin pulses are matched against an expected-pulse queue.
module tb_arcade_input_cond;
    localparam int NBTN        = 8;
    localparam int DEB_CNT     = 4;
    localparam int COIN_FRAMES = 2;
    localparam int COIN_GAP    = 2;

    logic            CLK = 1'b0;
    logic            RESET = 1'b0;
    logic            vblank = 1'b0;
    logic [NBTN-1:0] btn_in = '0;
    logic            coin_in = 1'b0;
    logic [NBTN-1:0] btn_out;
    logic            coin_out;
    logic            coin_busy;
    logic            coin_drop;

    arcade_input_cond #(
        .NBTN(NBTN),
        .DEB_W(16),
        .DEB_CNT(DEB_CNT),
        .COIN_FRAMES(COIN_FRAMES),
        .COIN_GAP(COIN_GAP),
        .QMAX(3)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .vblank(vblank),
        .btn_in(btn_in),
        .coin_in(coin_in),
        .btn_out(btn_out),
        .coin_out(coin_out),
        .coin_busy(coin_busy),
        .coin_drop(coin_drop)
    );

    typedef struct {
        logic [NBTN-1:0] pat;
        int              hold;
        logic [NBTN-1:0] exp;
    } vec_t;

    typedef struct {
        int width;
        bit gap_chk;
    } exp_pulse_t;

    exp_pulse_t sb[$];
    int total = 0;
    int bad = 0;
    int rise_cnt = 0;
    int drop_cnt = 0;
    int last_gap = -1;

    initial forever #5 CLK = ~CLK;

    // vblank high for one cycle every 20 cycles
    initial forever begin
        repeat (19) @(posedge CLK);
        #1 vblank = 1'b1;
        @(posedge CLK);
        #1 vblank = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input int h, input int l);
        coin_in = 1'b1;
        step(h);
        coin_in = 1'b0;
        step(l);
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n = 0;
        while (coin_busy && n < maxc) begin
            step(1);
            n++;
        end
        chk(name, int'(coin_busy), 0);
    endtask

    // Returns at the falling clock edge inside a vblank-high cycle.
    task automatic wait_tick();
        int n = 0;
        @(negedge CLK);
        while (!vblank && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("tick_seen", int'(vblank), 1);
    endtask

    // Pulse monitor: counts vblank ticks while coin_out is high (pulse width)
    // and while low-but-busy (gap), and checks them against the queue.
    initial begin
        logic prev_out;
        logic prev_busy;
        int hi_ticks;
        int lo_ticks;
        exp_pulse_t ep;
        prev_out = 1'b0;
        prev_busy = 1'b0;
        hi_ticks = 0;
        lo_ticks = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_out = 1'b0;
                prev_busy = 1'b0;
                hi_ticks = 0;
                lo_ticks = 0;
            end else begin
                if (coin_drop) drop_cnt++;
                if (coin_out && !prev_out) begin
                    rise_cnt++;
                    chk("pulse_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0 && sb[0].gap_chk)
                        chk("gap_ticks", lo_ticks, COIN_GAP);
                    hi_ticks = 0;
                end
                if (!coin_out && prev_out) begin
                    if (sb.size() > 0) begin
                        ep = sb.pop_front();
                        chk("pulse_ticks", hi_ticks, ep.width);
                    end
                    lo_ticks = 0;
                end
                if (coin_out && vblank) hi_ticks++;
                if (!coin_out && coin_busy && vblank) lo_ticks++;
                if (!coin_busy && prev_busy) last_gap = lo_ticks;
                prev_out = coin_out;
                prev_busy = coin_busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int r0;
        int d0;

        vecs[0] = '{pat: 8'h01, hold: 3,  exp: 8'h00};
        vecs[1] = '{pat: 8'h01, hold: 10, exp: 8'h01};
        vecs[2] = '{pat: 8'h20, hold: 4,  exp: 8'h20};
        vecs[3] = '{pat: 8'hA5, hold: 8,  exp: 8'hA5};
        vecs[4] = '{pat: 8'h80, hold: 1,  exp: 8'h00};

        #2 RESET = 1'b1;
        #1;
        chk("rst_btn_out", int'(btn_out), 0);
        chk("rst_coin_out", int'(coin_out), 0);
        chk("rst_coin_busy", int'(coin_busy), 0);
        chk("rst_coin_drop", int'(coin_drop), 0);
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        step(4);

        // Debounce: rise 6 cycles after the input edge, fall 6 after release
        foreach (vecs[v]) begin
            btn_in = vecs[v].pat;
            for (int c = 1; c <= vecs[v].hold + 8; c++) begin
                step(1);
                if (c == vecs[v].hold) btn_in = '0;
                if (c == 5) chk("vec_pre", int'(btn_out), 0);
                if (c == 6) chk("vec_rise", int'(btn_out), int'(vecs[v].exp));
                if (c > 6 && c == vecs[v].hold + 5 && vecs[v].exp != '0)
                    chk("vec_hold", int'(btn_out), int'(vecs[v].exp));
                if (c > 6 && c == vecs[v].hold + 6)
                    chk("vec_fall", int'(btn_out), 0);
            end
            step(4);
        end

        // Single coin press from IDLE
        r0 = rise_cnt;
        d0 = drop_cnt;
        last_gap = -1;
        sb.push_back('{width: COIN_FRAMES, gap_chk: 1'b0});
        coin_in = 1'b1;
        step(6);
        chk("t2_not_yet", int'(coin_out), 0);
        step(1);
        chk("t2_coin_out", int'(coin_out), 1);
        chk("t2_busy", int'(coin_busy), 1);
        step(1);
        coin_in = 1'b0;
        wait_idle(300, "t2_idle");
        step(5);
        chk("t2_gap_ticks", last_gap, COIN_GAP);
        chk("t2_pulses", rise_cnt - r0, 1);
        chk("t2_drops", drop_cnt - d0, 0);
        chk("t2_sb_empty", sb.size(), 0);

        // Four queued coins plus one dropped
        wait_tick();
        @(posedge CLK);
        #1;
        r0 = rise_cnt;
        d0 = drop_cnt;
        sb.push_back('{width: COIN_FRAMES, gap_chk: 1'b0});
        repeat (3) sb.push_back('{width: COIN_FRAMES, gap_chk: 1'b1});
        repeat (5) press(5, 5);
        wait_idle(1000, "t3_idle");
        step(5);
        chk("t3_pulses", rise_cnt - r0, 4);
        chk("t3_drops", drop_cnt - d0, 1);
        chk("t3_sb_empty", sb.size(), 0);

        // Coin event on the same cycle as a vblank tick
        wait_tick();
        @(posedge CLK);
        #1;
        step(13);
        r0 = rise_cnt;
        sb.push_back('{width: COIN_FRAMES, gap_chk: 1'b0});
        coin_in = 1'b1;
        step(5);
        coin_in = 1'b0;
        step(1);
        chk("t4_not_yet", int'(coin_out), 0);
        chk("t4_vblank_now", int'(vblank), 1);
        step(1);
        chk("t4_coin_out", int'(coin_out), 1);
        wait_idle(300, "t4_idle");
        step(5);
        chk("t4_pulses", rise_cnt - r0, 1);
        chk("t4_sb_empty", sb.size(), 0);

        // Reset in the middle of a pulse with two coins pending
        btn_in = 8'h04;
        step(10);
        chk("t5_btn_before", int'(btn_out), 4);
        wait_tick();
        @(posedge CLK);
        #1;
        sb.push_back('{width: COIN_FRAMES, gap_chk: 1'b0});
        repeat (3) press(5, 5);
        chk("t5_mid_pulse", int'(coin_out), 1);
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        btn_in = '0;
        sb.delete();
        #1;
        chk("t5_coin_out", int'(coin_out), 0);
        chk("t5_busy", int'(coin_busy), 0);
        chk("t5_btn_out", int'(btn_out), 0);
        @(posedge CLK);
        #3 RESET = 1'b0;
        r0 = rise_cnt;
        step(200);
        chk("t5_no_pulses", rise_cnt - r0, 0);
        chk("t5_busy_after", int'(coin_busy), 0);

        // Coin held for 200 cycles
        r0 = rise_cnt;
        sb.push_back('{width: COIN_FRAMES, gap_chk: 1'b0});
        coin_in = 1'b1;
        step(150);
        chk("t6_busy_held", int'(coin_busy), 0);
        step(50);
        coin_in = 1'b0;
        step(10);
        wait_idle(400, "t6_idle");
        step(5);
        chk("t6_pulses", rise_cnt - r0, 1);
        chk("t6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
